serial_alu: RTL
===============

# serial_alu

Parametrised bit-serial ALU: the successor to the single-op, fixed 4-bit serial NAND unit. It accepts two WIDTH-bit operands and a 3-bit opcode on a start pulse and processes one bit per clock, LSB first, with a registered carry chain. It publishes the result and carry/sign/zero flags atomically on completion, and holds them until the next completed operation. It sits beside the datapath register file as a low-area arithmetic/logic resource.

## Interface
- WIDTH, 4: operand/result width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  cancel the running operation; ignored in IDLE.
- A  in  WIDTH  operand A, latched on accepted start.
- B  in  WIDTH  operand B, latched on accepted start.
- opcode  in  3  operation, latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when C and the flags update.
- C  out  WIDTH  last completed result.
- car  out  1  carry flag.
- sign  out  1  C[WIDTH-1].
- zero  out  1  C == 0.
- ovf  out  1  signed overflow; present only with SERIAL_ALU_OVF_EN.

## Operation
- Opcodes: 000 ADD A+B; 001 SUB A−B (≈B, carry-in 1); 010 AND; 011 NAND; 100 OR; 101 XOR; 110 NOR; 111 PASSA (C=A).
- States: IDLE, RUN (2-state FSM; `default` → IDLE).
- IDLE with start=1:
  - latch A, B and opcode into shadow registers;
  - clear the bit index to 0;
  - load the carry register with 1 for SUB, else 0;
  - go to RUN.
- RUN, each cycle:
  - compute bit[idx] from the shadow operands and the carry register;
  - write the bit into the shadow result;
  - update the carry register (arithmetic ops only; logic ops keep it at 0);
  - increment idx.
- RUN, at idx == WIDTH−1:
  - the final bit is written;
  - C ← complete shadow result, including the final bit;
  - car ← final carry-out for ADD/SUB (SUB: 1 means no borrow), 0 for logic ops;
  - sign and zero are computed from the new result, never from the previous C;
  - done=1; state → IDLE.
- abort in RUN: → IDLE next edge; C, flags and done remain untouched; the partial result is discarded.
- A, B and opcode changes during RUN have no effect, because the unit works only on the shadow copies.
- start during RUN is ignored and not queued.

## Timing
- Accepted start at edge k: busy=1 after edge k. Bits 0..WIDTH−1 are computed at edges k+1..k+WIDTH.
- At edge k+WIDTH: C and the flags update, done=1 for exactly one cycle, and busy=0.
- Latency: WIDTH cycles from start to done. Throughput: one operation per WIDTH+1 cycles.
- Back-to-back: start may be high in the cycle done is high; it is accepted because the state is IDLE.
- abort and the final-bit edge coincide: abort wins; no done pulse, no update.
- Reset values: state IDLE, busy 0, done 0, C 0, car 0, sign 0, zero 1, ovf 0; shadow registers and idx 0.
- Reset asserted mid-operation: all of the above take effect immediately; no done pulse follows reset release.

## Configuration
- SERIAL_ALU_OVF_EN defined:
  - the ovf port exists;
  - on ADD/SUB completion, ovf ← carry into MSB XOR carry out of MSB;
  - on logic ops, ovf ← 0.
- SERIAL_ALU_OVF_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Package serial_alu_pkg:
  - opcode enum (OP_ADD…OP_PASSA);
  - FSM state enum (ST_IDLE, ST_RUN);
  - function returning the carry-in for an opcode.
- Sub-module serial_alu_bitslice: combinational one-bit cell.
  - Inputs: a, b, cin, opcode.
  - Outputs: r, cout.
  - Instantiated once; the top level holds the FSM, shadow registers, index counter and flag logic.

## Test plan
- WIDTH=4, NAND A=0101 B=0011, start one cycle → done at edge +4; C=1110, sign=1, zero=0, car=0; busy high for exactly 4 cycles.
- ADD A=1111 B=0001 → C=0000, car=1, zero=1, sign=0; with OVF_EN, ovf=0. ADD 0111+0001 → C=1000, ovf=1, sign=1.
- SUB A=0011 B=0101 → C=1110, car=0 (borrow). SUB 0101−0101 → C=0000, zero=1, car=1.
- Start AND 1100/1010; pulse abort at cycle 2 → no done; C keeps its prior value; new start accepted next cycle.
- Start during RUN and operand changes during RUN → ignored; result matches the originally latched operands. Back-to-back start on the done cycle → accepted.
- Assert rst mid-RUN → busy=0, C=0, zero=1 immediately; no done after release.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU: opcode and FSM state enums, plus
// helpers describing how each opcode uses the carry chain.
package serial_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_NAND  = 3'b011,
        OP_OR    = 3'b100,
        OP_XOR   = 3'b101,
        OP_NOR   = 3'b110,
        OP_PASSA = 3'b111
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Subtraction is A + ~B + 1, so its carry chain starts at 1.
    function automatic logic op_carry_in(input op_t op);
        return (op == OP_SUB);
    endfunction

    function automatic logic op_is_arith(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_bitslice.sv
// Combinational one-bit ALU cell; the carry output is forced low for logic
// opcodes so the serial carry register stays at 0 for them.
module serial_alu_bitslice
    import serial_alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  op_t  opcode,
    output logic r,
    output logic cout
);

    logic bx;

    always_comb begin
        bx   = (opcode == OP_SUB) ? ~b : b;
        r    = 1'b0;
        cout = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                r    = a ^ bx ^ cin;
                cout = (a & bx) | (cin & (a ^ bx));
            end
            OP_AND:   r = a & b;
            OP_NAND:  r = ~(a & b);
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOR:   r = ~(a | b);
            OP_PASSA: r = a;
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU, one result bit per clock LSB first; result and flags are
// published together on completion. Define SERIAL_ALU_OVF_EN to add ovf.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C,
    output logic             car,
    output logic             sign,
    output logic             zero
`ifdef SERIAL_ALU_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_r;
    op_t              sh_op;
    logic [IW-1:0]    idx;
    logic             cy;
    logic             bit_r;
    logic             bit_c;
    logic [WIDTH-1:0] res_next;

    serial_alu_bitslice u_slice (
        .a      (sh_a[idx]),
        .b      (sh_b[idx]),
        .cin    (cy),
        .opcode (sh_op),
        .r      (bit_r),
        .cout   (bit_c)
    );

    // Shadow result with the current bit merged in, so the final edge can
    // publish a complete value and derive sign/zero from it.
    always_comb begin
        res_next      = sh_r;
        res_next[idx] = bit_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            C     <= '0;
            car   <= 1'b0;
            sign  <= 1'b0;
            zero  <= 1'b1;
`ifdef SERIAL_ALU_OVF_EN
            ovf   <= 1'b0;
`endif
            sh_a  <= '0;
            sh_b  <= '0;
            sh_r  <= '0;
            sh_op <= OP_ADD;
            idx   <= '0;
            cy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sh_a  <= A;
                        sh_b  <= B;
                        sh_op <= op_t'(opcode);
                        sh_r  <= '0;
                        idx   <= '0;
                        cy    <= op_carry_in(op_t'(opcode));
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        sh_r <= res_next;
                        cy   <= op_is_arith(sh_op) ? bit_c : 1'b0;
                        idx  <= idx + 1'b1;
                        if (idx == LAST) begin
                            C     <= res_next;
                            car   <= op_is_arith(sh_op) ? bit_c : 1'b0;
                            sign  <= res_next[WIDTH-1];
                            zero  <= (res_next == '0);
`ifdef SERIAL_ALU_OVF_EN
                            ovf   <= op_is_arith(sh_op) ? (cy ^ bit_c) : 1'b0;
`endif
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
